// File: rtl/json_feedback_parser.sv
`timescale 1ns/1ps
// Byte-serial parser for motor-base feedback frames such as {"T":1001,"L":-120,"R":87}\n.
// Checks the grammar, range-checks each signed value and commits T/L/R together.
module json_feedback_parser #(
    parameter int VAL_W        = 16,
    parameter int MAX_DIGITS   = 5,
    parameter int TIMEOUT_CLKS = 100_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic signed [VAL_W-1:0] t_code,
    output logic signed [VAL_W-1:0] l_val,
    output logic signed [VAL_W-1:0] r_val,
    output logic [2:0]              fields_seen,
    output logic                    frame_valid,
    output logic                    frame_error,
    output logic                    busy
);
    localparam int ACC_W = VAL_W + 4;
    localparam int DIG_W = $clog2(MAX_DIGITS + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [ACC_W-1:0] POS_LIMIT = ACC_W'((64'd1 << (VAL_W - 1)) - 64'd1);
    localparam logic [ACC_W-1:0] NEG_LIMIT = ACC_W'(64'd1 << (VAL_W - 1));

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_T      = 8'h54;
    localparam logic [7:0] CH_L      = 8'h4C;
    localparam logic [7:0] CH_R      = 8'h52;

    typedef enum logic [3:0] {
        IDLE, KQ_OPEN, KEY, KQ_CLOSE, COLON,
        NUM_START, NUM_DIG0, NUM_DIGS, TERM, SKIP
    } state_t;

    state_t                     state;
    logic [1:0]                 key;       // 2 = T, 1 = L, 0 = R (matches fields_seen bits)
    logic                       neg;
    logic [ACC_W-1:0]           acc;
    logic [DIG_W-1:0]           dig_cnt;
    logic [CNT_W-1:0]           tmo_cnt;
    logic [2:0][VAL_W-1:0]      sh_val;
    logic [2:0]                 sh_seen;

    logic                       is_digit;
    logic                       is_key;
    logic [1:0]                 key_idx;
    logic [3:0]                 digit;
    logic [ACC_W-1:0]           acc_x10;
    logic [ACC_W-1:0]           acc_neg;
    logic [VAL_W-1:0]           store_val;
    logic                       mag_ok;
    logic                       restart;
    logic                       tok_ok;

    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign digit     = rx_data[3:0];
    assign acc_x10   = (acc << 3) + (acc << 1) + ACC_W'(digit);
    assign acc_neg   = '0 - acc;
    assign store_val = neg ? VAL_W'(acc_neg) : VAL_W'(acc);
    assign mag_ok    = neg ? (acc <= NEG_LIMIT) : (acc <= POS_LIMIT);
    assign busy      = (state != IDLE) && (state != SKIP);
    // '{' always starts a fresh frame; it only counts as an error when it interrupts one.
    assign restart   = rx_valid && (rx_data == CH_LBRACE);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        key_idx = 2'd0;
        is_key  = 1'b1;
        case (rx_data)
            CH_T:    key_idx = 2'd2;
            CH_L:    key_idx = 2'd1;
            CH_R:    key_idx = 2'd0;
            default: is_key  = 1'b0;
        endcase
    end

    always_comb begin
        tok_ok = 1'b1;
        case (state)
            KQ_OPEN, KQ_CLOSE: tok_ok = (rx_data == CH_QUOTE);
            KEY:               tok_ok = is_key;
            COLON:             tok_ok = (rx_data == CH_COLON);
            NUM_START:         tok_ok = is_digit || (rx_data == CH_MINUS);
            NUM_DIG0:          tok_ok = is_digit;
            NUM_DIGS:          tok_ok = (is_digit && (dig_cnt != DIG_W'(MAX_DIGITS)))
                                     || (((rx_data == CH_COMMA) || (rx_data == CH_RBRACE)) && mag_ok);
            TERM:              tok_ok = (rx_data == CH_LF) && sh_seen[2];
            default:           tok_ok = 1'b1;
        endcase
    end

    // NOTE: all state here is registered with non-blocking assignments so every
    // branch sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            key         <= '0;
            neg         <= 1'b0;
            acc         <= '0;
            dig_cnt     <= '0;
            tmo_cnt     <= '0;
            sh_val      <= '0;
            sh_seen     <= '0;
            t_code      <= '0;
            l_val       <= '0;
            r_val       <= '0;
            fields_seen <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            if (restart) begin
                tmo_cnt     <= '0;
                state       <= KQ_OPEN;
                sh_val      <= '0;
                sh_seen     <= '0;
                frame_error <= busy;
            end else if (rx_valid) begin
                tmo_cnt <= '0;
                if (!tok_ok) begin
                    frame_error <= 1'b1;
                    // A stray newline already ends the line, so there is nothing left to skip.
                    state <= (rx_data == CH_LF) ? IDLE : SKIP;
                end else begin
                    case (state)
                        SKIP:     if (rx_data == CH_LF) state <= IDLE;
                        KQ_OPEN:  state <= KEY;
                        KEY: begin
                            key   <= key_idx;
                            state <= KQ_CLOSE;
                        end
                        KQ_CLOSE: state <= COLON;
                        COLON:    state <= NUM_START;
                        NUM_START: begin
                            neg     <= !is_digit;
                            acc     <= is_digit ? ACC_W'(digit) : '0;
                            dig_cnt <= is_digit ? DIG_W'(1) : '0;
                            state   <= is_digit ? NUM_DIGS : NUM_DIG0;
                        end
                        NUM_DIG0: begin
                            acc     <= ACC_W'(digit);
                            dig_cnt <= DIG_W'(1);
                            state   <= NUM_DIGS;
                        end
                        NUM_DIGS: begin
                            if (is_digit) begin
                                acc     <= acc_x10;
                                dig_cnt <= dig_cnt + DIG_W'(1);
                            end else begin
                                sh_val[key]  <= store_val;
                                sh_seen[key] <= 1'b1;
                                state        <= (rx_data == CH_COMMA) ? KQ_OPEN : TERM;
                            end
                        end
                        TERM: begin
                            if (sh_seen[2]) t_code <= sh_val[2];
                            if (sh_seen[1]) l_val  <= sh_val[1];
                            if (sh_seen[0]) r_val  <= sh_val[0];
                            fields_seen <= sh_seen;
                            frame_valid <= 1'b1;
                            state       <= IDLE;
                        end
                        default: ;
                    endcase
                end
            end else if (busy) begin
                if (tmo_cnt == CNT_W'(TIMEOUT_CLKS - 1)) begin
                    frame_error <= 1'b1;
                    state       <= IDLE;
                    tmo_cnt     <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_W'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule
